// File: rtl/rle_pkg.sv
// Symbol format, special symbols and FSM state encoding for the RLE coefficient
// codec. The encoder and the decoder both import this package.
package rle_pkg;

  localparam int SYM_RUN_W  = 4;
  localparam int SYM_COEF_W = 12;
  localparam int ZRL_RUN    = 16;

  typedef struct packed {
    logic [SYM_RUN_W-1:0]         run;
    logic signed [SYM_COEF_W-1:0] value;
  } rle_sym_t;

  localparam rle_sym_t EOB = '{run: 4'd0,  value: 12'sd0};
  localparam rle_sym_t ZRL = '{run: 4'd15, value: 12'sd0};

  typedef enum logic [1:0] {
    ACCEPT = 2'd0,
    RUN    = 2'd1,
    VAL    = 2'd2,
    FILL   = 2'd3
  } rle_state_t;

endpackage

// File: rtl/rle_dec.sv
// Run-length decoder: expands (run, value) symbols into blocks of BLOCK_LEN
// coefficients on an AXI-stream output, one coefficient per cycle.
//
// state  | meaning
// ACCEPT | waiting for a symbol; its first coefficient is loaded on the handshake
// RUN    | emitting the remaining zeros of a run (or of a ZRL)
// VAL    | emitting the latched value after its run of zeros
// FILL   | padding zeros to the end of the block (EOB or run overflow)
module rle_dec
  import rle_pkg::*;
#(
  parameter int COEF_WIDTH = 12,
  parameter int RUN_WIDTH  = 4,
  parameter int BLOCK_LEN  = 64
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [RUN_WIDTH+COEF_WIDTH-1:0] s_axis_tdata,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic                            s_axis_tlast,
  output logic [COEF_WIDTH-1:0]           m_axis_tdata,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tlast,
  output logic                            m_axis_tuser,
  output logic                            err_o
);

  localparam int IDX_W = $clog2(BLOCK_LEN);
  localparam int SYM_W = RUN_WIDTH + COEF_WIDTH;
  localparam int CNT_W = RUN_WIDTH + 1;

  rle_state_t            state;
  logic [IDX_W-1:0]      idx;
  logic [CNT_W-1:0]      cnt;
  logic [COEF_WIDTH-1:0] val_q;
  logic                  zrl_q;
  logic                  blk_last;
  logic                  rdy_en;

  logic [RUN_WIDTH-1:0]  sym_run;
  logic [COEF_WIDTH-1:0] sym_val;
  logic                  can_load, sym_hs, is_eob, is_zrl, ovf, at_end, last_now;
  logic                  emit;
  logic [COEF_WIDTH-1:0] emit_val;

  assign sym_run  = s_axis_tdata[SYM_W-1 -: RUN_WIDTH];
  assign sym_val  = s_axis_tdata[COEF_WIDTH-1:0];
  assign can_load = !m_axis_tvalid || m_axis_tready;
  // rdy_en keeps tready low through reset and until the first edge after it
  assign s_axis_tready = rdy_en && (state == ACCEPT) && can_load;
  assign sym_hs   = s_axis_tvalid && s_axis_tready;
  assign is_eob   = (sym_run == RUN_WIDTH'(EOB.run)) && (sym_val == COEF_WIDTH'(EOB.value));
  assign is_zrl   = (sym_run == RUN_WIDTH'(ZRL.run)) && (sym_val == COEF_WIDTH'(ZRL.value));
  assign at_end   = (idx == IDX_W'(BLOCK_LEN - 1));
  assign last_now = blk_last || (sym_hs && s_axis_tlast);

  always_comb begin
    ovf = 1'b0;
    if (is_zrl)
      ovf = (int'(idx) + ZRL_RUN) > BLOCK_LEN;
    else if (!is_eob)
      ovf = (int'(idx) + int'(sym_run)) > (BLOCK_LEN - 1);
  end

  // The coefficient loaded into the output register this cycle, if any
  always_comb begin
    emit     = 1'b0;
    emit_val = '0;
    case (state)
      ACCEPT: begin
        emit = sym_hs;
        if (!is_eob && !is_zrl && !ovf && (sym_run == '0))
          emit_val = sym_val;
      end
      VAL: begin
        emit     = can_load;
        emit_val = val_q;
      end
      default: emit = can_load;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= ACCEPT;
      idx           <= '0;
      cnt           <= '0;
      val_q         <= '0;
      zrl_q         <= 1'b0;
      blk_last      <= 1'b0;
      rdy_en        <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tuser  <= 1'b0;
      m_axis_tlast  <= 1'b0;
      err_o         <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (can_load)
        m_axis_tvalid <= 1'b0;

      if (emit) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= emit_val;
        m_axis_tuser  <= (idx == '0);
        m_axis_tlast  <= at_end && last_now;
        idx           <= at_end ? '0 : idx + IDX_W'(1);
        blk_last      <= at_end ? 1'b0 : last_now;
      end

      case (state)
        ACCEPT: begin
          if (sym_hs) begin
            val_q <= sym_val;
            zrl_q <= is_zrl;
            if (is_eob || ovf) begin
              if (ovf)
                err_o <= 1'b1;
              state <= at_end ? ACCEPT : FILL;
            end else if (is_zrl) begin
              cnt   <= CNT_W'(ZRL_RUN - 1);
              state <= RUN;
            end else if (sym_run != '0) begin
              cnt   <= CNT_W'(sym_run) - CNT_W'(1);
              state <= (sym_run == RUN_WIDTH'(1)) ? VAL : RUN;
            end
          end
        end
        RUN: begin
          if (can_load) begin
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1))
              state <= zrl_q ? ACCEPT : VAL;
          end
        end
        VAL: begin
          if (can_load)
            state <= ACCEPT;
        end
        FILL: begin
          if (can_load && at_end)
            state <= ACCEPT;
        end
        default: state <= ACCEPT;
      endcase
    end
  end

endmodule

// File: tb/tb_rle_dec.sv
// Directed bench for rle_dec: expected coefficients are queued as symbols are
// issued, and a monitor compares every output handshake against the queue.
module tb_rle_dec;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [15:0] s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic        s_axis_tlast = 1'b0;
  logic [11:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b0;
  logic        m_axis_tlast;
  logic        m_axis_tuser;
  logic        err_o;

  rle_dec #(.COEF_WIDTH(12), .RUN_WIDTH(4), .BLOCK_LEN(64)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .m_axis_tuser(m_axis_tuser), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [11:0] d;
    logic        u;
    logic        l;
  } exp_t;

  exp_t exp_q[$];
  int   pop_cyc[$];
  int   exp_idx = 0;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;
  int   n_pops = 0;
  int   hs_cyc = 0;
  logic bp_en = 1'b0;
  logic ready_force = 1'b1;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic push_coef(input logic [11:0] d, input logic last_blk);
    exp_t e;
    e.d = d;
    e.u = (exp_idx == 0);
    e.l = last_blk && (exp_idx == 63);
    exp_q.push_back(e);
    exp_idx = (exp_idx == 63) ? 0 : exp_idx + 1;
  endtask

  task automatic push_zeros(input int n, input logic last_blk);
    for (int i = 0; i < n; i++) push_coef(12'd0, last_blk);
  endtask

  task automatic send(input logic [3:0] r, input logic [11:0] v, input logic last);
    int k;
    s_axis_tdata  = {r, v};
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    for (k = 0; k < 2000; k++) begin
      @(negedge clk_i);
      if (s_axis_tready) break;
    end
    if (k == 2000) check("send_timeout", 32'd1, 32'd0);
    hs_cyc = cyc + 1;
    @(posedge clk_i);
    #1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int k;
    for (k = 0; k < 3000; k++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk_i);
    end
    if (k == 3000) check(name, exp_q.size(), 32'd0);
    @(posedge clk_i);
    #1;
  endtask

  // Output ready: fixed level or random backpressure
  initial begin
    forever begin
      @(posedge clk_i);
      #1;
      m_axis_tready = bp_en ? 1'($urandom_range(0, 1)) : ready_force;
    end
  end

  // Monitor: pop and compare on every output handshake; check stability while stalled
  initial begin
    exp_t e;
    logic        stalled = 1'b0;
    logic [13:0] held = '0;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        stalled = 1'b0;
      end else begin
        if (stalled && m_axis_tvalid)
          check("stall_hold", {18'd0, m_axis_tdata, m_axis_tuser, m_axis_tlast}, {18'd0, held});
        if (m_axis_tvalid && m_axis_tready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_output", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("coef", {18'd0, m_axis_tdata, m_axis_tuser, m_axis_tlast}, {18'd0, e});
          end
          pop_cyc.push_back(cyc);
          n_pops++;
        end
        stalled = m_axis_tvalid && !m_axis_tready;
        held    = {m_axis_tdata, m_axis_tuser, m_axis_tlast};
      end
    end
  end

  initial begin
    int base;
    int first_hs;
    int k;

    // Reset state
    #1;
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_tready", s_axis_tready, 0);
    check("rst_err", err_o, 0);
    repeat (3) @(posedge clk_i);
    #3;
    rst_i = 1'b0;
    #1;
    check("tready_before_edge", s_axis_tready, 0);
    @(posedge clk_i);
    #1;
    check("tready_after_edge", s_axis_tready, 1);

    // (0,5),(2,-3),EOB: 5,0,0,-3 then 60 zeros at one coefficient per cycle
    base = n_pops;
    push_coef(12'd5, 1'b0);
    push_zeros(2, 1'b0);
    push_coef(12'hFFD, 1'b0);
    push_zeros(60, 1'b0);
    send(4'd0, 12'd5, 1'b0);
    first_hs = hs_cyc;
    send(4'd2, 12'hFFD, 1'b0);
    send(4'd0, 12'd0, 1'b0);
    wait_drain("drain_t1");
    check("t1_count", n_pops - base, 64);
    check("t1_latency", pop_cyc[base], first_hs);
    check("t1_rate", pop_cyc[base+63] - pop_cyc[base], 63);

    // ZRL,(3,7),EOB: 19 zeros, 7 at index 19, zeros to the end
    base = n_pops;
    push_zeros(19, 1'b0);
    push_coef(12'd7, 1'b0);
    push_zeros(44, 1'b0);
    send(4'd15, 12'd0, 1'b0);
    send(4'd3, 12'd7, 1'b0);
    send(4'd0, 12'd0, 1'b0);
    wait_drain("drain_t2");
    check("t2_count", n_pops - base, 64);

    // 64 x (0,1) fills a block without EOB; (0,2) then opens block 2
    base = n_pops;
    for (int i = 0; i < 64; i++) push_coef(12'd1, 1'b0);
    push_coef(12'd2, 1'b0);
    push_zeros(63, 1'b0);
    for (int i = 0; i < 64; i++) send(4'd0, 12'd1, 1'b0);
    send(4'd0, 12'd2, 1'b0);
    send(4'd0, 12'd0, 1'b0);
    wait_drain("drain_t3");
    check("t3_count", n_pops - base, 128);
    check("t3_err_clear", err_o, 0);

    // 62 x (0,1) then (5,9): run overflows, indices 62-63 zero, value dropped
    base = n_pops;
    for (int i = 0; i < 62; i++) push_coef(12'd1, 1'b0);
    push_zeros(2, 1'b0);
    for (int i = 0; i < 62; i++) send(4'd0, 12'd1, 1'b0);
    send(4'd5, 12'd9, 1'b0);
    wait_drain("drain_t4");
    check("t4_count", n_pops - base, 64);
    check("t4_err_set", err_o, 1);

    // Random backpressure; tlast on the final EOB of a two-block image
    base = n_pops;
    bp_en = 1'b1;
    push_coef(12'd0, 1'b0);
    push_coef(12'd3, 1'b0);
    push_coef(12'hFFF, 1'b0);
    push_zeros(61, 1'b0);
    push_zeros(2, 1'b1);
    push_coef(12'd6, 1'b1);
    push_zeros(61, 1'b1);
    send(4'd1, 12'd3, 1'b0);
    send(4'd0, 12'hFFF, 1'b0);
    send(4'd0, 12'd0, 1'b0);
    send(4'd2, 12'd6, 1'b0);
    send(4'd0, 12'd0, 1'b1);
    wait_drain("drain_t5");
    bp_en = 1'b0;
    @(posedge clk_i);
    #1;
    check("t5_count", n_pops - base, 128);
    check("t5_err_sticky", err_o, 1);

    // Reset pulsed while index 30 sits in the output register
    base = n_pops;
    push_zeros(30, 1'b0);
    send(4'd0, 12'd0, 1'b0);
    for (k = 0; k < 500; k++) begin
      @(posedge clk_i);
      #1;
      if (n_pops == base + 30) break;
    end
    check("t6_reach_30", n_pops - base, 30);
    check("t6_valid_before", m_axis_tvalid, 1);
    rst_i = 1'b1;
    #1;
    check("t6_rst_tvalid", m_axis_tvalid, 0);
    check("t6_rst_outs", {m_axis_tdata, m_axis_tuser, m_axis_tlast}, 14'd0);
    check("t6_rst_err", err_o, 0);
    check("t6_rst_tready", s_axis_tready, 0);
    exp_q.delete();
    exp_idx = 0;
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    check("t6_tready_held", s_axis_tready, 0);
    base = n_pops;
    push_coef(12'd4, 1'b0);
    push_zeros(63, 1'b0);
    send(4'd0, 12'd4, 1'b0);
    send(4'd0, 12'd0, 1'b0);
    wait_drain("drain_t6");
    check("t6_count", n_pops - base, 64);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
